// File: rtl/execution_pkg.sv
// Shared types for the memory-access stage: handshake FSM states,
// mem_ctl encodings and the writeback-control width.
package execution_pkg;

    localparam int WB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_LD   = 2'b01,
        MEM_ST   = 2'b10,
        MEM_ILL  = 2'b11
    } mem_ctl_e;

    function automatic logic is_ldst(input mem_ctl_e ctl);
        return (ctl == MEM_LD) || (ctl == MEM_ST);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus. The MEM stage is the master;
// the memory (or a bench model of it) is the slave.
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_handshake_fsm.sv
// IDLE/REQ/WAIT/DONE sequencer for one data-memory access; owns dmem_req and stall.
// Define MEM_STAGE_TIMEOUT_EN to add the ack wait counter and timeout abort.
module mem_handshake_fsm
    import execution_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       pend_i,
    input  logic       ack_i,
    output mem_state_e state_o,
    output logic       req_o,
    output logic       stall_o,
    output logic       ack_take_o,
    output logic       timeout_o
);

    mem_state_e state_q;
    logic       req_q;

    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("TIMEOUT must fit the 4-bit wait counter");
    end

    assign state_o    = state_q;
    assign req_o      = req_q;
    assign ack_take_o = req_q && ack_i;
    assign stall_o    = (state_q == REQ) || (state_q == WAIT) ||
                        ((state_q == IDLE) && pend_i);

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [3:0] wait_cnt_q;
    assign timeout_o = req_q && !ack_i && (wait_cnt_q == 4'(TIMEOUT - 1));
`else
    assign timeout_o = 1'b0;
`endif

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i || ((state_q == IDLE) && pend_i)) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
`ifdef MEM_STAGE_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REQ, WAIT: begin
                    if (ack_take_o || timeout_o) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                    end else begin
                        state_q <= WAIT;
`ifdef MEM_STAGE_TIMEOUT_EN
                        wait_cnt_q <= wait_cnt_q + 4'd1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load/store through the dmem bus, MM forwarding
// and the writeback bundle. MEM_STAGE_TIMEOUT_EN enables the ack timeout in the FSM.
module mem_stage
    import execution_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_busy,
    input  logic [1:0]        mem_ctl,
    input  logic [WB_W-1:0]   wb_in,
    input  logic              result_P,
    input  logic [DATA_W-1:0] result_I,
    input  logic [DATA_W-1:0] result_F,
    input  logic [DATA_W-1:0] wdata,
    mem_stage_if.master       dmem,
    output logic              stall_out,
    output logic              pval_mm,
    output logic [DATA_W-1:0] rval_mm,
    output logic [DATA_W-1:0] fval_mm,
    output logic              wb_valid,
    output logic [WB_W-1:0]   wb_ctl,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] wb_fdata,
    output logic              mem_fault
);

    typedef struct packed {
        mem_ctl_e          op;
        logic [WB_W-1:0]   wb;
        logic              pval;
        logic [DATA_W-1:0] rval;
        logic [DATA_W-1:0] fval;
        logic [DATA_W-1:0] sdata;
    } ex_mem_t;

    ex_mem_t    ex_mem_q, ex_mem_d;
    logic       fault_q, fault_d;
    mem_state_e state;
    mem_ctl_e   op_in;
    logic       capture, start, pend, req, ack_take, timeout;

    assign op_in   = mem_ctl_e'(mem_ctl);
    assign capture = !stall_out;
    assign start   = capture && !ex_busy && is_ldst(op_in);
    assign pend    = is_ldst(ex_mem_q.op);

    mem_handshake_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .pend_i    (pend),
        .ack_i     (dmem.dmem_ack),
        .state_o   (state),
        .req_o     (req),
        .stall_o   (stall_out),
        .ack_take_o(ack_take),
        .timeout_o (timeout)
    );

    // NOTE: defaulting every _d to its _q first keeps this block free of inferred latches.
    always_comb begin
        ex_mem_d = ex_mem_q;
        fault_d  = fault_q;
        if (capture) begin
            ex_mem_d = '{op: op_in, wb: wb_in, pval: result_P, rval: result_I,
                         fval: result_F, sdata: wdata};
            if (ex_busy) begin
                ex_mem_d.op = MEM_NONE;
                ex_mem_d.wb = '0;
            end else if (op_in == MEM_ILL) begin
                ex_mem_d.op = MEM_NONE;
                ex_mem_d.wb = '0;
                fault_d     = 1'b1;
            end else if (is_ldst(op_in) && (result_I[1:0] != 2'b00)) begin
                fault_d = 1'b1;
            end
        end else if (ack_take) begin
            // Load data overwrites the address slot, so forwarding and writeback pick it up.
            if (ex_mem_q.op == MEM_LD) ex_mem_d.rval = dmem.dmem_rdata;
        end else if (timeout) begin
            ex_mem_d.wb   = '0;
            ex_mem_d.rval = '0;
            fault_d       = 1'b1;
        end
    end

    // NOTE: reset is synchronous; only the EX/MEM register and fault flag need clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            ex_mem_q <= ex_mem_d;
            fault_q  <= fault_d;
        end
    end

    assign pval_mm   = ex_mem_q.pval;
    assign rval_mm   = ex_mem_q.rval;
    assign fval_mm   = ex_mem_q.fval;
    assign mem_fault = fault_q;

    assign wb_valid = (state == DONE) ||
                      ((state == IDLE) && (ex_mem_q.op == MEM_NONE) && (ex_mem_q.wb != '0));
    assign wb_ctl   = wb_valid ? ex_mem_q.wb   : '0;
    assign wb_data  = wb_valid ? ex_mem_q.rval : '0;
    assign wb_fdata = wb_valid ? ex_mem_q.fval : '0;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req && (ex_mem_q.op == MEM_ST);
    assign dmem.dmem_addr  = req ? {ex_mem_q.rval[DATA_W-1:2], 2'b00} : '0;
    assign dmem.dmem_wdata = req ? ex_mem_q.sdata : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a word-addressed memory model;
// exercises the timeout path when MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage;
    import execution_pkg::*;

    localparam int DW  = 32;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_busy;
    logic [1:0]    mem_ctl;
    logic [3:0]    wb_in;
    logic          result_P;
    logic [DW-1:0] result_I, result_F, wdata;
    logic          stall_out, pval_mm, wb_valid, mem_fault;
    logic [DW-1:0] rval_mm, fval_mm, wb_data, wb_fdata;
    logic [3:0]    wb_ctl;

    int n_checks = 0;
    int n_fails  = 0;

    logic [DW-1:0] ram   [0:15];
    logic [DW-1:0] model [0:15];

    mem_stage_if #(.DATA_W(DW)) dmem ();

    mem_stage #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ex_busy(ex_busy), .mem_ctl(mem_ctl), .wb_in(wb_in),
        .result_P(result_P), .result_I(result_I), .result_F(result_F), .wdata(wdata),
        .dmem(dmem), .stall_out(stall_out), .pval_mm(pval_mm), .rval_mm(rval_mm),
        .fval_mm(fval_mm), .wb_valid(wb_valid), .wb_ctl(wb_ctl), .wb_data(wb_data),
        .wb_fdata(wb_fdata), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic busy, input logic [1:0] ctl, input logic [3:0] wb,
                            input logic [DW-1:0] ri, input logic [DW-1:0] rf,
                            input logic [DW-1:0] wd, input logic p);
        ex_busy  = busy;
        mem_ctl  = ctl;
        wb_in    = wb;
        result_I = ri;
        result_F = rf;
        wdata    = wd;
        result_P = p;
    endtask

    task automatic drive_nop();
        drive_op(1'b0, MEM_NONE, 4'h0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        int            kind, idx, lat, reqs;
        logic [DW-1:0] addr, dval, fval, exp;
        logic [3:0]    wbv, ridx;
        logic          pv, is_st;

        rst = 1'b1;
        drive_nop();
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            ram[i]   = $urandom;
            model[i] = ram[i];
        end
        repeat (2) @(negedge clk);

        check("rst_stall", stall_out, 0);
        check("rst_req", dmem.dmem_req, 0);
        check("rst_addr", dmem.dmem_addr, 0);
        check("rst_valid", wb_valid, 0);
        check("rst_ctl", wb_ctl, 0);
        check("rst_data", wb_data, 0);
        check("rst_rval", rval_mm, 0);
        check("rst_fault", mem_fault, 0);
        rst = 1'b0;

        // ALU pass-through
        drive_op(1'b0, MEM_NONE, 4'b0011, 32'h10, 32'hF00D, '0, 1'b1);
        @(negedge clk);
        check("alu_valid", wb_valid, 1);
        check("alu_data", wb_data, 32'h10);
        check("alu_ctl", wb_ctl, 4'b0011);
        check("alu_fdata", wb_fdata, 32'hF00D);
        check("alu_pval", pval_mm, 1);
        check("alu_stall", stall_out, 0);
        drive_nop();
        @(negedge clk);
        check("alu_after", wb_valid, 0);

        // Load with ack in REQ
        drive_op(1'b0, MEM_LD, 4'b0101, 32'h100, '0, '0, 1'b0);
        @(negedge clk);
        check("ld0_req", dmem.dmem_req, 1);
        check("ld0_addr", dmem.dmem_addr, 32'h100);
        check("ld0_we", dmem.dmem_we, 0);
        check("ld0_stall", stall_out, 1);
        check("ld0_nvalid", wb_valid, 0);
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'hDEADBEEF;
        drive_nop();
        @(negedge clk);
        dmem.dmem_ack = 1'b0;
        check("ld0_req_drop", dmem.dmem_req, 0);
        check("ld0_stall_done", stall_out, 0);
        check("ld0_valid", wb_valid, 1);
        check("ld0_data", wb_data, 32'hDEADBEEF);
        check("ld0_rval", rval_mm, 32'hDEADBEEF);
        check("ld0_ctl", wb_ctl, 4'b0101);
        @(negedge clk);
        check("ld0_after", wb_valid, 0);

        // Store acknowledged on the fourth request cycle
        drive_op(1'b0, MEM_ST, 4'b0000, 32'h200, '0, 32'h12345678, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("st3_req", dmem.dmem_req, 1);
            check("st3_addr", dmem.dmem_addr, 32'h200);
            check("st3_wdata", dmem.dmem_wdata, 32'h12345678);
            check("st3_we", dmem.dmem_we, 1);
            check("st3_stall", stall_out, 1);
            check("st3_nvalid", wb_valid, 0);
            if (i == 3) begin
                dmem.dmem_ack = 1'b1;
                drive_nop();
            end
        end
        @(negedge clk);
        dmem.dmem_ack = 1'b0;
        check("st3_valid", wb_valid, 1);
        check("st3_data", wb_data, 32'h200);
        check("st3_req_drop", dmem.dmem_req, 0);
        check("st3_stall_done", stall_out, 0);
        @(negedge clk);
        check("st3_once", wb_valid, 0);

        // EX busy: five bubbles
        for (int i = 0; i < 5; i++) begin
            drive_op(1'b1, MEM_LD, 4'hF, 32'h300, '0, '0, 1'b0);
            @(negedge clk);
            check("bub_req", dmem.dmem_req, 0);
            check("bub_valid", wb_valid, 0);
            check("bub_ctl", wb_ctl, 0);
        end
        drive_nop();
        @(negedge clk);

        // Illegal mem_ctl, then misaligned load
        check("flt_pre", mem_fault, 0);
        drive_op(1'b0, MEM_ILL, 4'hF, 32'h44, '0, '0, 1'b0);
        @(negedge clk);
        check("ill_fault", mem_fault, 1);
        check("ill_req", dmem.dmem_req, 0);
        check("ill_valid", wb_valid, 0);
        check("ill_ctl", wb_ctl, 0);
        drive_nop();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ill_cleared", mem_fault, 0);

        drive_op(1'b0, MEM_LD, 4'h1, 32'h102, '0, '0, 1'b0);
        @(negedge clk);
        check("mis_req", dmem.dmem_req, 1);
        check("mis_addr", dmem.dmem_addr, 32'h100);
        check("mis_fault", mem_fault, 1);
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'hCAFE0001;
        drive_nop();
        @(negedge clk);
        dmem.dmem_ack = 1'b0;
        check("mis_data", wb_data, 32'hCAFE0001);
        check("mis_sticky", mem_fault, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mis_cleared", mem_fault, 0);

        // Reset in the middle of an access; a late ack must be ignored
        drive_op(1'b0, MEM_ST, 4'h0, 32'h40, '0, 32'hAA, 1'b0);
        @(negedge clk);
        check("rma_req", dmem.dmem_req, 1);
        drive_nop();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rma_req_drop", dmem.dmem_req, 0);
        check("rma_stall", stall_out, 0);
        dmem.dmem_ack = 1'b1;
        @(negedge clk);
        dmem.dmem_ack = 1'b0;
        check("rma_late_valid", wb_valid, 0);
        check("rma_late_req", dmem.dmem_req, 0);

`ifdef MEM_STAGE_TIMEOUT_EN
        reqs = 0;
        drive_op(1'b0, MEM_LD, 4'h7, 32'h80, '0, '0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive_nop();
            if (!dmem.dmem_req) break;
            reqs++;
        end
        check("tmo_req_cycles", reqs, TMO);
        check("tmo_valid", wb_valid, 1);
        check("tmo_ctl", wb_ctl, 0);
        check("tmo_data", wb_data, 0);
        check("tmo_fault", mem_fault, 1);
        check("tmo_stall", stall_out, 0);
`else
        drive_op(1'b0, MEM_LD, 4'h7, 32'h80, '0, '0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive_nop();
            check("hold_req", dmem.dmem_req, 1);
            check("hold_stall", stall_out, 1);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hold_released", dmem.dmem_req, 0);

        // Random back-to-back traffic against the programme-order memory model
        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, 15);
            lat  = $urandom_range(0, 3);
            addr = 32'h1000 + 32'(idx) * 4;
            wbv  = 4'($urandom);
            dval = $urandom;
            fval = $urandom;
            pv   = 1'($urandom);
            case (kind)
                0: begin
                    drive_op(1'b0, MEM_NONE, wbv, dval, fval, '0, pv);
                    @(negedge clk);
                    check("r_alu_valid", wb_valid, (wbv != 0));
                    check("r_alu_ctl", wb_ctl, wbv);
                    check("r_alu_data", wb_data, (wbv != 0) ? dval : '0);
                    check("r_alu_fdata", wb_fdata, (wbv != 0) ? fval : '0);
                    check("r_alu_rval", rval_mm, dval);
                    check("r_alu_pval", pval_mm, pv);
                end
                1: begin
                    drive_op(1'b1, 2'($urandom), wbv, dval, fval, dval, pv);
                    @(negedge clk);
                    check("r_bub_valid", wb_valid, 0);
                    check("r_bub_ctl", wb_ctl, 0);
                    check("r_bub_req", dmem.dmem_req, 0);
                end
                default: begin
                    is_st = (kind == 3);
                    drive_op(1'b0, is_st ? MEM_ST : MEM_LD, wbv, addr, fval, dval, pv);
                    if (is_st) begin
                        exp        = addr;
                        model[idx] = dval;
                    end else begin
                        exp = model[idx];
                    end
                    for (int c = 0; c <= lat; c++) begin
                        @(negedge clk);
                        check("r_hs_req", dmem.dmem_req, 1);
                        check("r_hs_addr", dmem.dmem_addr, addr);
                        check("r_hs_we", dmem.dmem_we, is_st);
                        check("r_hs_stall", stall_out, 1);
                        if (is_st) check("r_hs_wdata", dmem.dmem_wdata, dval);
                        if (c == lat) begin
                            ridx            = dmem.dmem_addr[5:2];
                            dmem.dmem_rdata = ram[ridx];
                            if (dmem.dmem_we) ram[ridx] = dmem.dmem_wdata;
                            dmem.dmem_ack   = 1'b1;
                        end
                        drive_op(1'b0, 2'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 1'b0);
                    end
                    @(negedge clk);
                    dmem.dmem_ack = 1'b0;
                    check("r_done_valid", wb_valid, 1);
                    check("r_done_ctl", wb_ctl, wbv);
                    check("r_done_data", wb_data, exp);
                    check("r_done_rval", rval_mm, exp);
                    check("r_done_stall", stall_out, 0);
                    check("r_done_req", dmem.dmem_req, 0);
                    drive_nop();
                end
            endcase
        end
        drive_nop();
        @(negedge clk);
        check("r_no_fault", mem_fault, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
